// File: rtl/hazard_scoreboard_if.sv
// Decode-to-scoreboard bundle: decode request and flush in, stall/forwarding decision and occupancy out.
// master = decode side, slave = scoreboard side.
interface hazard_scoreboard_if #(
    parameter int DEPTH   = 3,
    parameter int NUM_SRC = 2,
    parameter int REG_AW  = 5
);
    localparam int SW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic                      de_v;
    logic                      de_wen;
    logic [REG_AW-1:0]         de_dr;
    logic                      de_is_load;
    logic [NUM_SRC-1:0]        de_src_v;
    logic [NUM_SRC*REG_AW-1:0] de_src;
    logic                      flush;
    logic [SW-1:0]             flush_stage;
    logic                      stall;
    logic [NUM_SRC-1:0]        fwd_hit;
    logic [NUM_SRC*SW-1:0]     fwd_stage;
    logic [SW:0]               inflight_cnt;

    modport master (
        output de_v, de_wen, de_dr, de_is_load, de_src_v, de_src, flush, flush_stage,
        input  stall, fwd_hit, fwd_stage, inflight_cnt
    );

    modport slave (
        input  de_v, de_wen, de_dr, de_is_load, de_src_v, de_src, flush, flush_stage,
        output stall, fwd_hit, fwd_stage, inflight_cnt
    );
endinterface

// File: rtl/hazard_scoreboard.sv
// Tracks in-flight destination registers and decides stall/forward source for decode; outputs are
// combinational from state and inputs, state advances every edge with no back-pressure below decode.
module hazard_scoreboard #(
    parameter int DEPTH      = 3,
    parameter int NUM_SRC    = 2,
    parameter int REG_AW     = 5,
    parameter int ALU_READY  = 1,
    parameter int LOAD_READY = 2,
    parameter int FWD_EN     = 1
) (
    input  logic              clk,
    input  logic              rst,
    hazard_scoreboard_if.slave sb
);
    localparam int SW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DEPTH-1:0]             v;
    logic [DEPTH-1:0]             ld;
    logic [DEPTH-1:0][REG_AW-1:0] dr;

    logic [DEPTH-1:0]      rdy;
    logic [DEPTH-1:1]      keep;
    logic [NUM_SRC-1:0]    src_stall;
    logic [NUM_SRC-1:0]    hit_raw;
    logic [NUM_SRC*SW-1:0] stage_raw;
    logic                  stall_int;
    logic                  issue;
    logic [SW:0]           cnt;

    always_comb begin
        rdy = '0;
        for (int s = 0; s < DEPTH; s++) begin
            rdy[s] = ld[s] ? (s >= LOAD_READY) : (s >= ALU_READY);
        end
    end

    // Scan oldest to youngest so the youngest matching producer overwrites older ones.
    always_comb begin
        logic              found;
        logic              frdy;
        logic [SW-1:0]     fs;
        logic [REG_AW-1:0] src;
        src_stall = '0;
        hit_raw   = '0;
        stage_raw = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            found = 1'b0;
            frdy  = 1'b0;
            fs    = '0;
            src   = sb.de_src[i*REG_AW +: REG_AW];
            for (int s = DEPTH - 1; s >= 0; s--) begin
                if (sb.de_src_v[i] && (src != '0) && v[s] && (dr[s] == src)) begin
                    found = 1'b1;
                    frdy  = rdy[s];
                    fs    = SW'(s);
                end
            end
            if (FWD_EN != 0) begin
                src_stall[i] = found & ~frdy;
                hit_raw[i]   = found & frdy;
            end else begin
                src_stall[i] = found;
                hit_raw[i]   = 1'b0;
            end
            stage_raw[i*SW +: SW] = fs;
        end
    end

    assign stall_int = sb.de_v & (|src_stall);
    assign sb.stall  = stall_int;

    always_comb begin
        sb.fwd_hit   = '0;
        sb.fwd_stage = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            sb.fwd_hit[i] = hit_raw[i] & sb.de_v & ~stall_int;
            if (sb.fwd_hit[i]) begin
                sb.fwd_stage[i*SW +: SW] = stage_raw[i*SW +: SW];
            end
        end
    end

    // A flush kills everything younger than the redirecting stage; the redirector itself moves on.
    always_comb begin
        keep = '1;
        for (int s = 1; s < DEPTH; s++) begin
            keep[s] = ~(sb.flush && (SW'(s - 1) < sb.flush_stage));
        end
    end

    assign issue = sb.de_v & sb.de_wen & (|sb.de_dr) & ~stall_int & ~sb.flush;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v  <= '0;
            ld <= '0;
            dr <= '0;
        end else begin
            v[0]  <= issue;
            ld[0] <= issue & sb.de_is_load;
            dr[0] <= issue ? sb.de_dr : '0;
            for (int s = 1; s < DEPTH; s++) begin
                v[s]  <= v[s-1] & keep[s];
                ld[s] <= ld[s-1];
                dr[s] <= dr[s-1];
            end
        end
    end

    always_comb begin
        cnt = '0;
        for (int s = 0; s < DEPTH; s++) begin
            cnt = cnt + (SW+1)'(v[s]);
        end
    end

    assign sb.inflight_cnt = cnt;
endmodule
